// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types and sizing for the I/D-cache miss arbiter in front of unified main memory.
// Holds FSM state encodings, owner encoding, default latency/block size and the block-base helper.
package mem_fill_arbiter_pkg;

  localparam int unsigned MEM_LAT = 4;
  localparam int unsigned WORDS   = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned WIDX_W  = $clog2(WORDS);

  localparam logic [WIDX_W-1:0] LAST_IDX   = WIDX_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(2 * WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } wrReq_t;

  // Block base by masking only, so a fill never crosses the top of memory.
  function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] a);
    return a & BLOCK_MASK;
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Cache-side and memory-side signal bundle of mem_fill_arbiter.
// slave = arbiter view, master = caches plus memory view.
interface mem_fill_arbiter_if;
  import mem_fill_arbiter_pkg::*;

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              dc_req;
  logic              dc_wr;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] fill_data;
  logic [WIDX_W-1:0] fill_word;
  logic              ic_fill_we;
  logic              dc_fill_we;
  logic              ic_done;
  logic              dc_done;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_rdata, mem_rvalid,
    output fill_data, fill_word, ic_fill_we, dc_fill_we, ic_done, dc_done,
           mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_rdata, mem_rvalid,
    input  fill_data, fill_word, ic_fill_we, dc_fill_we, ic_done, dc_done,
           mem_en, mem_wr, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the I/D miss arbiter.
// MEM_ARB_RR_EN defined: ties alternate against the last winner; otherwise D always beats I.
module mem_arb_pick (
  input  logic icReq,
  input  logic dcReq,
  input  logic lastWinnerD,
  output logic grantD,
  output logic grantAny
);

`ifdef MEM_ARB_RR_EN
  // On a tie, D wins only if I won the previous grant.
  assign grantD = dcReq & (~icReq | ~lastWinnerD);
`else
  logic unusedLastWinner;
  assign unusedLastWinner = lastWinnerD;
  assign grantD           = dcReq;
`endif

  assign grantAny = icReq | dcReq;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache misses onto pipelined main memory: 8-word block fills and
// single-word D write-throughs. Build option MEM_ARB_RR_EN selects round-robin tie breaking.
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mem_fill_arbiter_if.slave bus
);

  arbState_t         state;
  owner_t            owner;
  logic [WIDX_W-1:0] issueCnt;
  logic [WIDX_W-1:0] recvCnt;
  logic [ADDR_W-1:0] baseAddr;
  wrReq_t            wrReq;
  logic              lastWinnerD;
  logic              grantD;
  logic              grantAny;
  logic              acceptRet;
  logic              lastRet;

  mem_arb_pick uPick (
    .icReq       (bus.ic_req),
    .dcReq       (bus.dc_req),
    .lastWinnerD (lastWinnerD),
    .grantD      (grantD),
    .grantAny    (grantAny)
  );

  // Returns are only meaningful while a fill is in flight; anything else is dropped.
  assign acceptRet = bus.mem_rvalid && ((state == ISSUE) || (state == DRAIN));
  assign lastRet   = acceptRet && (recvCnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_I;
      issueCnt    <= '0;
      recvCnt     <= '0;
      baseAddr    <= '0;
      wrReq       <= '0;
      lastWinnerD <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grantAny) begin
            lastWinnerD <= grantD;
            if (grantD && bus.dc_wr) begin
              owner       <= OWN_D;
              wrReq.addr  <= bus.dc_addr & ~ADDR_W'(1);
              wrReq.wdata <= bus.dc_wdata;
              state       <= WRITE;
            end else begin
              owner    <= grantD ? OWN_D : OWN_I;
              baseAddr <= blockBase(grantD ? bus.dc_addr : bus.ic_addr);
              issueCnt <= '0;
              recvCnt  <= '0;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          issueCnt <= issueCnt + WIDX_W'(1);
          if (issueCnt == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          if (lastRet) state <= IDLE;
        end
        WRITE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (acceptRet) recvCnt <= recvCnt + WIDX_W'(1);
    end
  end

  assign bus.fill_data  = acceptRet ? bus.mem_rdata : '0;
  assign bus.fill_word  = recvCnt;
  assign bus.ic_fill_we = acceptRet && (owner == OWN_I);
  assign bus.dc_fill_we = acceptRet && (owner == OWN_D);
  assign bus.ic_done    = lastRet && (owner == OWN_I);
  assign bus.dc_done    = (lastRet && (owner == OWN_D)) || (state == WRITE);

  // Memory side depends only on state, counters and latched request fields.
  assign bus.mem_en    = (state == ISSUE) || (state == WRITE);
  assign bus.mem_wr    = (state == WRITE);
  assign bus.mem_addr  = (state == ISSUE) ? (baseAddr | (ADDR_W'(issueCnt) << 1)) :
                         (state == WRITE) ? wrReq.addr : '0;
  assign bus.mem_wdata = (state == WRITE) ? wrReq.wdata : '0;
  assign bus.busy      = (state != IDLE);

endmodule
